// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared types and constants for the ysyx_24110006 load/store unit.
package ysyx_24110006_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Reserved funct3 codes (011, 11x) all land on the word size here.
  function automatic logic [1:0] load_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   load_size = SZ_BYTE;
      2'b01:   load_size = SZ_HALF;
      default: load_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] store_size(input logic [3:0] wmask);
    case (wmask)
      4'b1111: store_size = SZ_WORD;
      4'b0011: store_size = SZ_HALF;
      default: store_size = SZ_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24110006_lsu_if.sv
// Data-bus request/response channel between the LSU (master) and memory (slave).
interface ysyx_24110006_lsu_if #(
  parameter int XLEN = 32,
  parameter int SZ_W = 2
);
  logic            o_req_valid;
  logic            i_req_ready;
  logic            o_req_wen;
  logic [XLEN-1:0] o_req_addr;
  logic [SZ_W-1:0] o_req_size;
  logic [XLEN-1:0] o_req_wdata;
  logic [3:0]      o_req_wstrb;
  logic            i_rsp_valid;
  logic [XLEN-1:0] i_rsp_rdata;
  logic            i_rsp_err;
  logic            o_rsp_ready;

  modport master (
    output o_req_valid, o_req_wen, o_req_addr, o_req_size, o_req_wdata, o_req_wstrb, o_rsp_ready,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err
  );

  modport slave (
    input  o_req_valid, o_req_wen, o_req_addr, o_req_size, o_req_wdata, o_req_wstrb, o_rsp_ready,
    output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err
  );
endinterface

// File: rtl/ysyx_24110006_lsu_align.sv
// Combinational store lane shift, load extract and misalign detect.
// Misalign detect is present only when YSYX_LSU_MISALIGN_CHECK_EN is defined.
module ysyx_24110006_lsu_align
  import ysyx_24110006_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SZ_W = 2
) (
  input  logic            i_wen,
  input  logic [2:0]      i_read_t,
  input  logic [3:0]      i_wmask,
  input  logic [1:0]      i_req_off,
  input  logic [XLEN-1:0] i_wdata,
  output logic [SZ_W-1:0] o_size,
  output logic [3:0]      o_wstrb,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_misalign,
  input  logic [1:0]      i_ld_off,
  input  logic [2:0]      i_ld_read_t,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_ldata
);

  logic [SZ_W-1:0] w_size;
  logic [XLEN-1:0] w_sh;

  assign w_size  = i_wen ? store_size(i_wmask) : load_size(i_read_t);
  assign o_size  = w_size;
  // Lanes shifted past byte 3 fall off the 4-bit strobe / 32-bit data.
  assign o_wstrb = i_wen ? (i_wmask << i_req_off) : 4'b0000;
  assign o_wdata = i_wdata << {i_req_off, 3'b000};

`ifdef YSYX_LSU_MISALIGN_CHECK_EN
  assign o_misalign = ((w_size == SZ_HALF) && (i_req_off == 2'd3)) ||
                      ((w_size == SZ_WORD) && (i_req_off != 2'd0));
`else
  assign o_misalign = 1'b0;
`endif

  assign w_sh = i_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ldata = w_sh;
    case (i_ld_read_t)
      F3_LB:   o_ldata = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
      F3_LH:   o_ldata = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
      F3_LBU:  o_ldata = {{(XLEN-8){1'b0}}, w_sh[7:0]};
      F3_LHU:  o_ldata = {{(XLEN-16){1'b0}}, w_sh[15:0]};
      F3_LW:   o_ldata = w_sh;
      default: o_ldata = w_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit: one bus transaction per load/store, one-cycle passthrough otherwise.
// Optional misaligned-access trap enabled by YSYX_LSU_MISALIGN_CHECK_EN.
module ysyx_24110006_lsu
  import ysyx_24110006_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SZ_W = 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic                       i_mem_ren,
  input  logic                       i_mem_wen,
  input  logic [2:0]                 i_mem_read_t,
  input  logic [3:0]                 i_mem_wmask,
  input  logic [XLEN-1:0]            i_mem_addr,
  input  logic [XLEN-1:0]            i_wdata,
  input  logic [XLEN-1:0]            i_result,
  ysyx_24110006_lsu_if.master        bus,
  output logic                       o_valid,
  output logic [XLEN-1:0]            o_wb_data,
  output logic                       o_err
);

  lsu_state_e      r_state;
  lsu_state_e      w_next;

  logic            r_wen;
  logic [XLEN-1:0] r_addr;
  logic [SZ_W-1:0] r_size;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wstrb;
  logic [2:0]      r_read_t;
  logic [XLEN-1:0] r_wb_data;
  logic            r_err;

  logic            w_mem;
  logic            w_start;
  logic            w_misalign;
  logic            w_rsp_fire;
  logic [SZ_W-1:0] w_size;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_ldata;

  assign w_mem      = i_mem_ren | i_mem_wen;
  assign w_start    = i_valid && (r_state == IDLE);
  assign w_rsp_fire = (r_state == RSP) && bus.i_rsp_valid;

  ysyx_24110006_lsu_align #(
    .XLEN (XLEN),
    .SZ_W (SZ_W)
  ) u_align (
    .i_wen       (i_mem_wen),
    .i_read_t    (i_mem_read_t),
    .i_wmask     (i_mem_wmask),
    .i_req_off   (i_mem_addr[1:0]),
    .i_wdata     (i_wdata),
    .o_size      (w_size),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_misalign  (w_misalign),
    .i_ld_off    (r_addr[1:0]),
    .i_ld_read_t (r_read_t),
    .i_rdata     (bus.i_rsp_rdata),
    .o_ldata     (w_ldata)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (i_valid) w_next = (w_mem && !w_misalign) ? REQ : DONE;
      REQ:  if (bus.i_req_ready) w_next = RSP;
      RSP:  if (bus.i_rsp_valid) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request fields are only observed while o_req_valid is high, so they carry no reset.
  always_ff @(posedge i_clock) begin
    if (w_start && w_mem) begin
      r_wen    <= i_mem_wen;
      r_addr   <= i_mem_addr;
      r_size   <= w_size;
      r_wdata  <= w_wdata;
      r_wstrb  <= w_wstrb;
      r_read_t <= i_mem_read_t;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wb_data <= '0;
      r_err     <= 1'b0;
    end else if (w_start && !w_mem) begin
      r_wb_data <= i_result;
      r_err     <= 1'b0;
    end else if (w_start && w_misalign) begin
      r_wb_data <= '0;
      r_err     <= 1'b1;
    end else if (w_rsp_fire) begin
      r_wb_data <= (bus.i_rsp_err || r_wen) ? '0 : w_ldata;
      r_err     <= bus.i_rsp_err;
    end
  end

  assign bus.o_req_valid = (r_state == REQ);
  assign bus.o_req_wen   = r_wen;
  assign bus.o_req_addr  = r_addr;
  assign bus.o_req_size  = r_size;
  assign bus.o_req_wdata = r_wdata;
  assign bus.o_req_wstrb = r_wstrb;
  assign bus.o_rsp_ready = (r_state == RSP);

  assign o_valid   = (r_state == DONE);
  assign o_err     = (r_state == DONE) && r_err;
  assign o_wb_data = r_wb_data;

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Directed bench for ysyx_24110006_lsu; honours YSYX_LSU_MISALIGN_CHECK_EN.
module tb_ysyx_24110006_lsu;
  import ysyx_24110006_lsu_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [2:0]  i_mem_read_t;
  logic [3:0]  i_mem_wmask;
  logic [31:0] i_mem_addr;
  logic [31:0] i_wdata;
  logic [31:0] i_result;
  logic        o_valid;
  logic [31:0] o_wb_data;
  logic        o_err;

  int n_chk = 0;
  int n_err = 0;

  ysyx_24110006_lsu_if #(.XLEN(32), .SZ_W(2)) bus ();

  ysyx_24110006_lsu #(.XLEN(32), .SZ_W(2)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_mem_ren    (i_mem_ren),
    .i_mem_wen    (i_mem_wen),
    .i_mem_read_t (i_mem_read_t),
    .i_mem_wmask  (i_mem_wmask),
    .i_mem_addr   (i_mem_addr),
    .i_wdata      (i_wdata),
    .i_result     (i_result),
    .bus          (bus),
    .o_valid      (o_valid),
    .o_wb_data    (o_wb_data),
    .o_err        (o_err)
  );

  always #5 i_clock = ~i_clock;

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp_wb,
                         input logic [1:0] exp_size);
    i_valid = 1'b1; i_mem_ren = 1'b1; i_mem_wen = 1'b0;
    i_mem_read_t = f3; i_mem_addr = addr;
    bus.i_req_ready = 1'b1; bus.i_rsp_valid = 1'b1; bus.i_rsp_err = 1'b0;
    bus.i_rsp_rdata = rdata;
    step();
    i_valid = 1'b0; i_mem_ren = 1'b0;
    chk({tag, "_req_valid"}, 32'(bus.o_req_valid), 32'h1);
    chk({tag, "_req_wen"},   32'(bus.o_req_wen), 32'h0);
    chk({tag, "_req_size"},  32'(bus.o_req_size), 32'(exp_size));
    chk({tag, "_req_addr"},  bus.o_req_addr, addr);
    chk({tag, "_req_wstrb"}, 32'(bus.o_req_wstrb), 32'h0);
    chk({tag, "_early_vld"}, 32'(o_valid), 32'h0);
    step();
    chk({tag, "_rsp_ready"}, 32'(bus.o_rsp_ready), 32'h1);
    chk({tag, "_req_drop"},  32'(bus.o_req_valid), 32'h0);
    step();
    chk({tag, "_valid"},     32'(o_valid), 32'h1);
    chk({tag, "_wb"},        o_wb_data, exp_wb);
    chk({tag, "_err"},       32'(o_err), 32'h0);
    step();
    chk({tag, "_pulse_end"}, 32'(o_valid), 32'h0);
  endtask

  initial begin
    logic [31:0] req_addr_s, req_wdata_s;
    i_reset = 1'b1; i_valid = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0;
    i_mem_read_t = 3'b000; i_mem_wmask = 4'b0000; i_mem_addr = '0;
    i_wdata = '0; i_result = '0;
    bus.i_req_ready = 1'b0; bus.i_rsp_valid = 1'b0; bus.i_rsp_rdata = '0; bus.i_rsp_err = 1'b0;

    step(); step();
    chk("rst_valid",     32'(o_valid), 32'h0);
    chk("rst_req_valid", 32'(bus.o_req_valid), 32'h0);
    chk("rst_rsp_ready", 32'(bus.o_rsp_ready), 32'h0);
    chk("rst_err",       32'(o_err), 32'h0);
    chk("rst_wb",        o_wb_data, 32'h0);
    i_reset = 1'b0;
    step();

    // Non-memory passthrough, latency 1
    i_valid = 1'b1; i_result = 32'h1234_5678;
    step();
    i_valid = 1'b0; i_result = 32'h0;
    chk("alu_valid",     32'(o_valid), 32'h1);
    chk("alu_wb",        o_wb_data, 32'h1234_5678);
    chk("alu_no_req",    32'(bus.o_req_valid), 32'h0);
    step();
    chk("alu_pulse_end", 32'(o_valid), 32'h0);
    chk("alu_wb_hold",   o_wb_data, 32'h1234_5678);

    do_load("lb",   F3_LB,  32'h8000_0003, 32'h80FF_FFFF, 32'hFFFF_FF80, SZ_BYTE);
    do_load("lhu",  F3_LHU, 32'h8000_0002, 32'hBEEF_0000, 32'h0000_BEEF, SZ_HALF);
    do_load("lh",   F3_LH,  32'h8000_0002, 32'hBEEF_0000, 32'hFFFF_BEEF, SZ_HALF);
    do_load("lbu",  F3_LBU, 32'h8000_0001, 32'h0000_9C00, 32'h0000_009C, SZ_BYTE);
    do_load("lw",   F3_LW,  32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, SZ_WORD);
    do_load("rsvd", 3'b011, 32'h8000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D, SZ_WORD);

    // SB with a 4-cycle request stall and an ignored i_valid pulse
    bus.i_req_ready = 1'b0;
    i_valid = 1'b1; i_mem_wen = 1'b1; i_mem_wmask = 4'b0001;
    i_mem_addr = 32'h8000_0001; i_wdata = 32'h0000_00AB;
    step();
    i_valid = 1'b0; i_mem_wen = 1'b0; i_mem_wmask = 4'b0000; i_wdata = '0;
    chk("sb_req_valid", 32'(bus.o_req_valid), 32'h1);
    chk("sb_req_wen",   32'(bus.o_req_wen), 32'h1);
    chk("sb_wstrb",     32'(bus.o_req_wstrb), 32'h2);
    chk("sb_wdata",     bus.o_req_wdata, 32'h0000_AB00);
    chk("sb_size",      32'(bus.o_req_size), 32'(SZ_BYTE));
    req_addr_s = bus.o_req_addr; req_wdata_s = bus.o_req_wdata;
    chk("sb_addr",      req_addr_s, 32'h8000_0001);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin i_valid = 1'b1; i_result = 32'hCAFE_0000; end
      step();
      i_valid = 1'b0;
      chk("sb_stall_valid", 32'(bus.o_req_valid), 32'h1);
      chk("sb_stall_addr",  bus.o_req_addr, req_addr_s);
      chk("sb_stall_wdata", bus.o_req_wdata, req_wdata_s);
      chk("sb_stall_wstrb", 32'(bus.o_req_wstrb), 32'h2);
      chk("sb_stall_done",  32'(o_valid), 32'h0);
    end
    bus.i_req_ready = 1'b1;
    step();
    chk("sb_rsp_ready", 32'(bus.o_rsp_ready), 32'h1);
    step();
    chk("sb_valid", 32'(o_valid), 32'h1);
    chk("sb_wb",    o_wb_data, 32'h0);
    chk("sb_err",   32'(o_err), 32'h0);
    step();
    chk("sb_single_pulse", 32'(o_valid), 32'h0);
    step();
    chk("sb_no_ghost", 32'(o_valid), 32'h0);

    // LW with a bus error
    bus.i_rsp_err = 1'b1; bus.i_rsp_rdata = 32'hFFFF_FFFF;
    i_valid = 1'b1; i_mem_ren = 1'b1; i_mem_read_t = F3_LW; i_mem_addr = 32'h8000_0010;
    step();
    i_valid = 1'b0; i_mem_ren = 1'b0;
    step(); step();
    chk("lwerr_valid", 32'(o_valid), 32'h1);
    chk("lwerr_err",   32'(o_err), 32'h1);
    chk("lwerr_wb",    o_wb_data, 32'h0);
    bus.i_rsp_err = 1'b0;
    step();
    chk("lwerr_err_clear", 32'(o_err), 32'h0);

    // Asynchronous reset in the middle of REQ
    bus.i_req_ready = 1'b0;
    i_valid = 1'b1; i_mem_ren = 1'b1; i_mem_read_t = F3_LW; i_mem_addr = 32'h8000_0020;
    step();
    i_valid = 1'b0; i_mem_ren = 1'b0;
    chk("arst_pre_req", 32'(bus.o_req_valid), 32'h1);
    #2 i_reset = 1'b1;
    #1;
    chk("arst_req_drop", 32'(bus.o_req_valid), 32'h0);
    chk("arst_rsp_drop", 32'(bus.o_rsp_ready), 32'h0);
    chk("arst_valid",    32'(o_valid), 32'h0);
    step();
    i_reset = 1'b0;
    step();
    chk("arst_idle", 32'(bus.o_req_valid), 32'h0);

    // SW at offset 2
    bus.i_req_ready = 1'b1; bus.i_rsp_valid = 1'b1;
    i_valid = 1'b1; i_mem_wen = 1'b1; i_mem_wmask = 4'b1111;
    i_mem_addr = 32'h8000_0002; i_wdata = 32'h1122_3344;
    step();
    i_valid = 1'b0; i_mem_wen = 1'b0;
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
    chk("swmis_no_req", 32'(bus.o_req_valid), 32'h0);
    chk("swmis_valid",  32'(o_valid), 32'h1);
    chk("swmis_err",    32'(o_err), 32'h1);
    chk("swmis_wb",     o_wb_data, 32'h0);
`else
    chk("swmis_req",    32'(bus.o_req_valid), 32'h1);
    chk("swmis_wstrb",  32'(bus.o_req_wstrb), 32'hC);
    chk("swmis_wdata",  bus.o_req_wdata, 32'h3344_0000);
    chk("swmis_size",   32'(bus.o_req_size), 32'(SZ_WORD));
    step(); step();
    chk("swmis_valid",  32'(o_valid), 32'h1);
    chk("swmis_err",    32'(o_err), 32'h0);
`endif
    step();
    chk("swmis_end", 32'(o_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule
